sha_256_padder: RTL and testbench

SHA_256_PADDER -- requirements
Module: sha_256_padder

---
 rtl/sha_256_padder.sv | 174 +++++++++++++++++
 tb/tb_sha_256_padder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha_256_padder.sv
`default_nettype none
// ============================================================================
// Module      : sha_256_padder
// Description : Byte-serial SHA-256 message padder. Collects message bytes
//               into 512-bit blocks, appends the 0x80 marker, zero fill and
//               the 64-bit big-endian bit length, and hands each finished
//               block to the compression stage with a valid/ready handshake.
// Ports       : clk, rst_n            clock, async active-low reset
//               i_byte/i_valid/i_last message byte stream (in)
//               o_ready                 byte accepted this cycle
//               o_block/o_valid/o_last  padded block stream (out)
//               i_ready                 downstream takes o_block
//               Byte 0 of a block sits at o_block[511:504].
// Revision    : 1.0  initial release
// ============================================================================
module sha_256_padder (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   i_byte,
    input  logic         i_valid,
    input  logic         i_last,
    output logic         o_ready,
    output logic [511:0] o_block,
    output logic         o_valid,
    output logic         o_last,
    input  logic         i_ready
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PAD   = 2'd1,
        EXTRA = 2'd2,
        EMIT  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [5:0]     pos_q, pos_d;
    logic [60:0]    msg_len_q, msg_len_d;
    logic [511:0]   block_q, block_d;
    logic           last_q, last_d;
    logic           pad_pending_q, pad_pending_d;
    logic           extra_pending_q, extra_pending_d;
    // Held low through reset and set on the first clock after release so
    // that no byte is taken while rst_n is low.
    logic           rdy_en_q, rdy_en_d;

    logic           take_in;
    logic [63:0]    len_bits;
    logic [8:0]     wr_lsb;

    assign o_ready  = (state_q == FILL) && rdy_en_q;
    assign o_valid  = (state_q == EMIT);
    assign o_last   = last_q;
    assign o_block  = block_q;

    assign take_in  = i_valid && o_ready;
    // Bit length wraps modulo 2^64 by construction.
    assign len_bits = {msg_len_q, 3'b000};
    // LSB of byte cnt: byte 0 lives at the top, so offset is (63-cnt)*8.
    assign wr_lsb   = {~cnt_q, 3'b000};

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pos_d           = pos_q;
        msg_len_d       = msg_len_q;
        block_d         = block_q;
        last_d          = last_q;
        pad_pending_d   = pad_pending_q;
        extra_pending_d = extra_pending_q;
        rdy_en_d        = 1'b1;

        case (state_q)
            FILL: begin
                if (take_in) begin
                    block_d[wr_lsb +: 8] = i_byte;
                    cnt_d     = cnt_q + 6'd1;
                    msg_len_d = msg_len_q + 61'd1;
                    if (i_last) begin
                        if (cnt_q == 6'd63) begin
                            // Block is full of data; padding goes in a fresh block.
                            state_d       = EMIT;
                            last_d        = 1'b0;
                            pad_pending_d = 1'b1;
                        end else begin
                            state_d = PAD;
                            pos_d   = cnt_q + 6'd1;
                        end
                    end else if (cnt_q == 6'd63) begin
                        state_d = EMIT;
                        last_d  = 1'b0;
                    end
                end
            end

            PAD: begin
                for (int i = 0; i < 64; i++) begin
                    if (6'(i) == pos_q) begin
                        block_d[(63 - i) * 8 +: 8] = 8'h80;
                    end else if (6'(i) > pos_q) begin
                        block_d[(63 - i) * 8 +: 8] = 8'h00;
                    end
                end
                state_d = EMIT;
                if (pos_q <= 6'd55) begin
                    block_d[63:0] = len_bits;
                    last_d        = 1'b1;
                end else begin
                    // No room for the length field; it needs an extra block.
                    last_d          = 1'b0;
                    extra_pending_d = 1'b1;
                end
            end

            EXTRA: begin
                block_d = {448'd0, len_bits};
                state_d = EMIT;
                last_d  = 1'b1;
            end

            EMIT: begin
                if (i_ready) begin
                    if (extra_pending_q) begin
                        state_d         = EXTRA;
                        extra_pending_d = 1'b0;
                    end else if (pad_pending_q) begin
                        state_d       = PAD;
                        pos_d         = 6'd0;
                        pad_pending_d = 1'b0;
                    end else if (last_q) begin
                        state_d   = FILL;
                        cnt_d     = 6'd0;
                        msg_len_d = 61'd0;
                        last_d    = 1'b0;
                    end else begin
                        state_d = FILL;
                        cnt_d   = 6'd0;
                    end
                end
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= FILL;
            cnt_q           <= 6'd0;
            pos_q           <= 6'd0;
            msg_len_q       <= 61'd0;
            block_q         <= 512'd0;
            last_q          <= 1'b0;
            pad_pending_q   <= 1'b0;
            extra_pending_q <= 1'b0;
            rdy_en_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pos_q           <= pos_d;
            msg_len_q       <= msg_len_d;
            block_q         <= block_d;
            last_q          <= last_d;
            pad_pending_q   <= pad_pending_d;
            extra_pending_q <= extra_pending_d;
            rdy_en_q        <= rdy_en_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha_256_padder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha_256_padder
// Description : Self-checking bench for sha_256_padder. A reference padder
//               pushes expected blocks into a scoreboard queue as each
//               message is driven; a monitor pops and compares on every
//               output handshake.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sha_256_padder;

    logic         clk;
    logic         rst_n;
    logic [7:0]   i_byte;
    logic         i_valid;
    logic         i_last;
    logic         o_ready;
    logic [511:0] o_block;
    logic         o_valid;
    logic         o_last;
    logic         i_ready;

    int n_checks = 0;
    int n_pass   = 0;

    logic [512:0] sb_q[$];   // {last, block}

    sha_256_padder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_byte  (i_byte),
        .i_valid (i_valid),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_block (o_block),
        .o_valid (o_valid),
        .o_last  (o_last),
        .i_ready (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", tag, got, exp);
    endtask

    // Reference SHA-256 padding: message, 0x80, zeros to 56 mod 64, 64-bit length.
    task automatic push_expected(input logic [7:0] msg[$]);
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] blk;
        int           nblk;
        p    = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bits[k*8 +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            for (int j = 0; j < 64; j++) blk[(63 - j) * 8 +: 8] = p[b*64 + j];
            sb_q.push_back({(b == nblk - 1) ? 1'b1 : 1'b0, blk});
        end
    endtask

    // Drives bytes one per handshake; i_last on the final byte if with_last.
    task automatic send_msg(input logic [7:0] msg[$], input bit with_last);
        int guard;
        for (int k = 0; k < msg.size(); k++) begin
            i_valid = 1'b1;
            i_byte  = msg[k];
            i_last  = with_last && (k == msg.size() - 1);
            guard   = 0;
            forever begin
                @(negedge clk);
                if (o_ready) break;
                guard++;
                if (guard > 200) begin
                    chk("in_timeout", 512'd0, 512'd1);
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    // Scoreboard monitor: the handshake occurs at the posedge after this sample.
    always @(negedge clk) begin
        logic [512:0] e;
        if (rst_n && o_valid && i_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 512'(sb_q.size()), 512'd1);
            end else begin
                e = sb_q.pop_front();
                chk("sb_block", o_block, e[511:0]);
                chk("sb_last", 512'(o_last), 512'(e[512]));
            end
        end
    end

    task automatic drain();
        int guard = 0;
        while (sb_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        chk("drain", 512'(sb_q.size()), 512'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]   m[$];
        logic [7:0]   abc[$];
        logic [511:0] held;
        logic         held_last;
        int           guard;

        abc = '{8'h61, 8'h62, 8'h63};
        rst_n   = 1'b0;
        i_byte  = 8'h00;
        i_valid = 1'b1;      // must be ignored during reset
        i_last  = 1'b0;
        i_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_o_ready", 512'(o_ready), 512'd0);
        chk("rst_o_valid", 512'(o_valid), 512'd0);
        chk("rst_o_last",  512'(o_last),  512'd0);
        chk("rst_o_block", o_block, 512'd0);
        i_valid = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", 512'(o_ready), 512'd1);
        @(posedge clk); #1;

        // "abc" with latency and literal block check
        push_expected(abc);
        send_msg(abc, 1'b1);
        @(negedge clk);
        chk("abc_lat_pad", 512'(o_valid), 512'd0);
        @(negedge clk);
        chk("abc_lat_valid", 512'(o_valid), 512'd1);
        chk("abc_literal", o_block, {32'h61626380, 416'd0, 64'h18});
        drain();

        // 55 bytes: padding and length fit in one block
        m = {};
        for (int k = 0; k < 55; k++) m.push_back(8'h41);
        push_expected(m); send_msg(m, 1'b1); drain();

        // 56 bytes: length spills into an extra block
        m = {};
        for (int k = 0; k < 56; k++) m.push_back(8'h41);
        push_expected(m); send_msg(m, 1'b1); drain();

        // 64 bytes: full data block then pad-only block
        m = {};
        for (int k = 0; k < 64; k++) m.push_back(8'(k));
        push_expected(m); send_msg(m, 1'b1); drain();

        // Backpressure during EMIT
        i_ready = 1'b0;
        m = {};
        for (int k = 0; k < 10; k++) m.push_back(8'(k * 7 + 3));
        push_expected(m);
        send_msg(m, 1'b1);
        guard = 0;
        while (!o_valid && guard < 50) begin @(negedge clk); guard++; end
        chk("bp_valid", 512'(o_valid), 512'd1);
        held = o_block; held_last = o_last;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_block", o_block, held);
            chk("bp_flags", {509'd0, o_valid, o_last, o_ready}, {509'd0, 1'b1, held_last, 1'b0});
        end
        @(posedge clk); #1;
        i_ready = 1'b1;
        drain();

        // Reset after 20 bytes, then "abc"
        m = {};
        for (int k = 0; k < 20; k++) m.push_back(8'h5A);
        send_msg(m, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 512'(o_ready), 512'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_expected(abc);
        send_msg(abc, 1'b1);
        drain();

        // Back-to-back "abc", "abc"
        push_expected(abc);
        push_expected(abc);
        send_msg(abc, 1'b1);
        send_msg(abc, 1'b1);
        drain();

        // A few random lengths across block boundaries
        for (int r = 0; r < 4; r++) begin
            m = {};
            for (int k = 0; k < 100 + r * 9; k++) m.push_back(8'($urandom));
            push_expected(m); send_msg(m, 1'b1);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
